// File: rtl/aes_pkg.sv
// Shared AES-128 constants, the round-constant and S-box tables, and the
// state type of the inverse key expander.
package aes_pkg;

  localparam int AES_KEY_W  = 128;
  localparam int AES_WORD_W = 32;
  localparam int AES_ROUNDS = 10;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } inv_key_state_t;

  // Rcon[r] is the round constant used to build round key r+1.
  function automatic logic [7:0] aes_rcon(input logic [3:0] r);
    logic [7:0] c;
    case (r)
      4'd0:    c = 8'h01;
      4'd1:    c = 8'h02;
      4'd2:    c = 8'h04;
      4'd3:    c = 8'h08;
      4'd4:    c = 8'h10;
      4'd5:    c = 8'h20;
      4'd6:    c = 8'h40;
      4'd7:    c = 8'h80;
      4'd8:    c = 8'h1b;
      4'd9:    c = 8'h36;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] AES_SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] aes_sbox(input logic [7:0] x);
    return AES_SBOX[(255 - int'(x)) * 8 +: 8];
  endfunction

endpackage

// File: rtl/keyScheduleCore.sv
// Key schedule core: RotWord, SubWord, then XOR of Rcon[roundNumber]
// into the most significant byte.
module keyScheduleCore
  import aes_pkg::*;
(
  input  logic [AES_WORD_W-1:0] inputWord,
  input  logic [3:0]            roundNumber,
  output logic [AES_WORD_W-1:0] outputWord
);

  logic [AES_WORD_W-1:0] rot_word;

  assign rot_word = {inputWord[23:0], inputWord[31:24]};

  assign outputWord = {aes_sbox(rot_word[31:24]) ^ aes_rcon(roundNumber),
                       aes_sbox(rot_word[23:16]),
                       aes_sbox(rot_word[15:8]),
                       aes_sbox(rot_word[7:0])};

endmodule

// File: rtl/inv_key_expander.sv
// Sequential AES-128 inverse key schedule: emits round keys 10 down to 0.
// Optional INV_KEY_ABORT_EN adds a key_abort input that cancels a walk.
module inv_key_expander
  import aes_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [AES_KEY_W-1:0] last_key,
  input  logic                 key_ready,
`ifdef INV_KEY_ABORT_EN
  input  logic                 key_abort,
`endif
  output logic [AES_KEY_W-1:0] round_key,
  output logic [3:0]           round_num,
  output logic                 key_valid,
  output logic                 busy,
  output logic                 done
);

  // Handshake: a key is transferred on every rising clk edge where
  // key_valid && key_ready; while key_ready is low the key and its index hold.

  inv_key_state_t        state, state_nxt;
  logic [AES_KEY_W-1:0]  key_nxt, prev_key;
  logic [3:0]            num_nxt;
  logic                  done_nxt;
  logic                  abort_req;
  logic [AES_WORD_W-1:0] a_p, b_p, c_p, d_p;
  logic [AES_WORD_W-1:0] a_r, b_r, c_r, d_r;
  logic [AES_WORD_W-1:0] core_word;

`ifdef INV_KEY_ABORT_EN
  assign abort_req = key_abort;
`else
  assign abort_req = 1'b0;
`endif

  assign {a_p, b_p, c_p, d_p} = round_key;

  // Undo the forward recurrence: the last three words first, then the
  // first word needs the recovered d to rebuild the core term.
  assign d_r = d_p ^ c_p;
  assign c_r = c_p ^ b_p;
  assign b_r = b_p ^ a_p;
  assign a_r = a_p ^ core_word;
  assign prev_key = {a_r, b_r, c_r, d_r};

  keyScheduleCore u_core (
    .inputWord   (d_r),
    .roundNumber (round_num - 4'd1),
    .outputWord  (core_word)
  );

  assign key_valid = (state == RUN);
  assign busy      = (state == RUN);

  always_comb begin
    state_nxt = state;
    key_nxt   = round_key;
    num_nxt   = round_num;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
          key_nxt   = last_key;
          num_nxt   = 4'(AES_ROUNDS);
        end
      end
      RUN: begin
        if (abort_req) begin
          state_nxt = IDLE;
          key_nxt   = '0;
          num_nxt   = '0;
        end else if (key_ready) begin
          if (round_num == 4'd0) begin
            // Walk complete; key material is not left in the register.
            state_nxt = IDLE;
            done_nxt  = 1'b1;
            key_nxt   = '0;
            num_nxt   = '0;
          end else begin
            key_nxt = prev_key;
            num_nxt = round_num - 4'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      round_key <= '0;
      round_num <= '0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      round_key <= key_nxt;
      round_num <= num_nxt;
      done      <= done_nxt;
    end
  end

endmodule

// File: tb/tb_inv_key_expander.sv
// Testbench for inv_key_expander: a forward AES-128 key expansion (S-box
// derived from GF(2^8) inverses) predicts the 11 round keys of each walk.
module tb_inv_key_expander;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [127:0] last_key = '0;
  logic         key_ready = 1'b0;
  logic         key_abort = 1'b0;
  logic [127:0] round_key;
  logic [3:0]   round_num;
  logic         key_valid;
  logic         busy;
  logic         done;

  int checks = 0;
  int errors = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  inv_key_expander dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .last_key  (last_key),
    .key_ready (key_ready),
`ifdef INV_KEY_ABORT_EN
    .key_abort (key_abort),
`endif
    .round_key (round_key),
    .round_num (round_num),
    .key_valid (key_valid),
    .busy      (busy),
    .done      (done)
  );

  // ---------------- reference model ----------------
  logic [7:0]   sbox_t [256];
  logic [7:0]   rcon_t [10];
  logic [127:0] rk [11];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] t = {b, b};
    t = t << n;
    return t[15:8];
  endfunction

  task automatic build_tables();
    logic [7:0] inv;
    logic [7:0] r;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                  ^ rotl8(inv, 4) ^ 8'h63;
    end
    r = 8'h01;
    for (int i = 0; i < 10; i++) begin
      rcon_t[i] = r;
      r = gmul(r, 8'h02);
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  task automatic compute_model(input logic [127:0] k0);
    logic [31:0] w [44];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = k0[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) t = sub_word({t[23:0], t[31:24]}) ^ {rcon_t[i/4 - 1], 24'h0};
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // ---------------- scoreboard ----------------
  logic [131:0] exp_q[$];
  bit           exp_done = 1'b0;
  bit           held = 1'b0;
  logic [131:0] held_val = '0;
  int           hs_count = 0;

  task automatic check(input string name, input logic [131:0] act, input logic [131:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic flush_scoreboard();
    exp_q.delete();
    exp_done = 1'b0;
    held = 1'b0;
  endtask

  // Monitor: samples on the falling edge, i.e. the values the next rising
  // edge will act on.
  always @(negedge clk) begin
    logic [131:0] e;
    if (!rst) begin
      check("done", 132'(done), 132'(exp_done));
      exp_done = 1'b0;
      check("busy_vs_valid", 132'(busy), 132'(key_valid));
      if (key_valid) begin
        if (held) check("hold_stable", {round_num, round_key}, held_val);
        if (key_ready && !key_abort) begin
          hs_count++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_key: got %h expected none", {round_num, round_key});
          end else begin
            e = exp_q.pop_front();
            check("round_key", {round_num, round_key}, e);
            if (e[131:128] == 4'd0) exp_done = 1'b1;
          end
          held = 1'b0;
        end else begin
          held = 1'b1;
          held_val = {round_num, round_key};
        end
      end else begin
        held = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_walk(input logic [127:0] lk);
    hs_count = 0;
    start = 1'b1;
    last_key = lk;
    for (int r = 10; r >= 0; r--) exp_q.push_back({4'(r), rk[r]});
    tick();
    start = 1'b0;
    check("start_latency", 132'({key_valid, busy, round_num}), 132'({1'b1, 1'b1, 4'd10}));
  endtask

  task automatic run_to_done(input bit bp);
    int n = 0;
    do begin
      key_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      n++;
    end while (!done && n < 400);
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL walk_timeout: got no done expected done within 400 cycles");
    end
    check("handshakes", 132'(hs_count), 132'(11));
    check("queue_empty", 132'(exp_q.size()), 132'(0));
  endtask

  task automatic step_to_round(input logic [3:0] target);
    int n = 0;
    key_ready = 1'b1;
    while (!(key_valid && round_num == target) && n < 50) begin
      tick();
      n++;
    end
    check("reach_round", 132'(round_num), 132'(target));
  endtask

  task automatic new_random_key();
    compute_model({$urandom, $urandom, $urandom, $urandom});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    build_tables();
    tick();
    check("reset_key", 132'(round_key), 132'(0));
    check("reset_flags", 132'({round_num, key_valid, busy, done}), 132'(0));
    tick();
    rst = 1'b0;
    tick();

    // FIPS-197 vector with published round keys pinned as constants.
    compute_model(128'h2b7e151628aed2a6abf7158809cf4f3c);
    rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    start_walk(128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    run_to_done(1'b0);

    // Back-to-back: start issued during the done cycle.
    new_random_key();
    start_walk(rk[10]);
    run_to_done(1'b0);

    // Random keys with random backpressure.
    for (int i = 0; i < 6; i++) begin
      key_ready = 1'b0;
      repeat ($urandom_range(0, 3)) tick();
      new_random_key();
      start_walk(rk[10]);
      run_to_done(1'b1);
    end

    // Start while busy is ignored.
    new_random_key();
    start_walk(rk[10]);
    step_to_round(4'd5);
    start = 1'b1;
    last_key = {$urandom, $urandom, $urandom, $urandom};
    tick();
    start = 1'b0;
    run_to_done(1'b1);

    // Reset mid-walk clears everything at once; a new walk restarts at 10.
    tick();
    new_random_key();
    start_walk(rk[10]);
    step_to_round(4'd6);
    rst = 1'b1;
    #1;
    check("midrst_key", 132'(round_key), 132'(0));
    check("midrst_flags", 132'({round_num, key_valid, busy, done}), 132'(0));
    flush_scoreboard();
    tick();
    tick();
    rst = 1'b0;
    tick();
    new_random_key();
    start_walk(rk[10]);
    run_to_done(1'b1);

`ifdef INV_KEY_ABORT_EN
    // Abort at round 3 wins over a simultaneous handshake.
    tick();
    new_random_key();
    start_walk(rk[10]);
    step_to_round(4'd3);
    key_abort = 1'b1;
    key_ready = 1'b1;
    tick();
    key_abort = 1'b0;
    check("abort_flags", 132'({key_valid, busy, round_num}), 132'(0));
    check("abort_key", 132'(round_key), 132'(0));
    flush_scoreboard();
    tick();
    check("abort_no_done", 132'(done), 132'(0));
    new_random_key();
    start_walk(rk[10]);
    run_to_done(1'b1);
`endif

    repeat (3) tick();
    check("final_idle", 132'({busy, key_valid}), 132'(0));
    check("final_queue", 132'(exp_q.size()), 132'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
